// File: rtl/sec_lock_pipe.sv
// sec_lock_pipe: two-stage single-error-correcting decode pipeline whose
// syndrome is gated by a serially loaded key. The decode is only correct once
// the key that matches KEY_INV has been committed.
// Optional feature: define SEC_LOCK_ERR_COUNT_EN to enable the saturating
// err_cnt counter of corrected/flagged output words.
module sec_lock_pipe #(
    parameter int               DATA_W  = 32,
    parameter int               CHK_W   = 8,
    parameter logic [CHK_W-1:0] KEY_INV = {CHK_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_shift,
    input  logic              key_bit,
    input  logic              key_commit,
    output logic              key_armed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CHK_W-1:0]  check_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              corr_flag,
    output logic              err_flag,
    output logic [7:0]        err_cnt
);

    // Every data column must be a distinct non-power-of-two check value.
    if (DATA_W + CHK_W > (2 ** CHK_W) - 1) begin : g_param_check
        $error("sec_lock_pipe: DATA_W + CHK_W must not exceed 2**CHK_W - 1");
    end

    // Data bit i uses the (i+1)-th non-power-of-two value starting at 3.
    function automatic logic [DATA_W-1:0][CHK_W-1:0] build_cols();
        logic [DATA_W-1:0][CHK_W-1:0] cols;
        int n;
        cols = '0;
        n    = 0;
        for (int v = 3; v < (2 ** CHK_W); v++) begin
            if (((v & (v - 1)) != 0) && (n < DATA_W)) begin
                cols[n] = v[CHK_W-1:0];
                n++;
            end
        end
        return cols;
    endfunction

    localparam logic [DATA_W-1:0][CHK_W-1:0] H_COLS = build_cols();

    typedef enum logic [1:0] {LOCKED, SHIFT, ARMED} key_state_t;

    key_state_t        key_state, key_next;
    logic              key_load;
    logic [CHK_W-1:0]  key_shadow, key_act;
    logic [CHK_W-1:0]  raw_syn, eff_syn;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [CHK_W-1:0]  s1_e;
    logic              s2_ready;
    logic [DATA_W-1:0] dec_data;
    logic              dec_corr, dec_err, dec_hit;

    // Key FSM state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_state <= LOCKED;
        else        key_state <= key_next;
    end

    // Key FSM next state; a shift always wins over a same-cycle commit.
    // NOTE: defaults are assigned first so no path leaves a variable unassigned
    // and no latch is inferred.
    always_comb begin
        key_next = key_state;
        key_load = 1'b0;
        if (key_shift) begin
            key_next = SHIFT;
        end else if (key_commit && (key_state == SHIFT)) begin
            key_next = ARMED;
            key_load = 1'b1;
        end
    end

    assign key_armed = (key_state == ARMED);

    // Shadow shift register (LSB-first key enters at the MSB) and active key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_shadow <= '0;
            key_act    <= '0;
        end else begin
            if (key_shift) key_shadow <= {key_bit, key_shadow[CHK_W-1:1]};
            if (key_load)  key_act    <= key_shadow;
        end
    end

    // Raw syndrome of the incoming word, then key gating.
    always_comb begin
        raw_syn = check_in;
        for (int i = 0; i < DATA_W; i++) begin
            if (data_in[i]) raw_syn = raw_syn ^ H_COLS[i];
        end
        eff_syn = raw_syn ^ key_act ^ KEY_INV;
    end

    // A stage advances when its downstream stage is empty or draining.
    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    // Stage 1: capture the word with the syndrome computed under the key
    // active at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_e     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= data_in;
                s1_e    <= eff_syn;
            end
        end
    end

    // Syndrome decode: correct a data bit, accept a check-bit error, or flag.
    always_comb begin
        dec_data = s1_data;
        dec_hit  = 1'b0;
        dec_corr = 1'b0;
        dec_err  = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (s1_e == H_COLS[i]) begin
                dec_data[i] = ~s1_data[i];
                dec_hit     = 1'b1;
            end
        end
        if (s1_e != '0) begin
            if (dec_hit || ((s1_e & (s1_e - 1'b1)) == '0)) dec_corr = 1'b1;
            else                                           dec_err  = 1'b1;
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            corr_flag <= 1'b0;
            err_flag  <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out  <= dec_data;
                corr_flag <= dec_corr;
                err_flag  <= dec_err;
            end
        end
    end

`ifdef SEC_LOCK_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of delivered words that needed correction or were bad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (out_valid && out_ready && (corr_flag || err_flag)
                     && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sec_lock_pipe.sv
// Testbench for sec_lock_pipe (DATA_W=32, CHK_W=8, KEY_INV=8'hA5).
// Expected words are queued as transfers are accepted and compared in order
// as the DUT delivers them.
module tb_sec_lock_pipe;

    localparam logic [7:0] KEY_INV = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_shift, key_bit, key_commit, key_armed;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] data_in, data_out;
    logic [7:0]  check_in, err_cnt;
    logic        corr_flag, err_flag;

    typedef struct packed {
        logic [31:0] data;
        logic        corr;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    exp_t       held;
    logic       stall_prev = 1'b0;
    logic [7:0] tb_key = 8'h00;
    int         checks = 0;
    int         failures = 0;
    int         n_out = 0;

    sec_lock_pipe #(.DATA_W(32), .CHK_W(8), .KEY_INV(KEY_INV)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_shift(key_shift), .key_bit(key_bit), .key_commit(key_commit),
        .key_armed(key_armed),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .check_in(check_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .corr_flag(corr_flag), .err_flag(err_flag), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // H column of data bit idx: idx-th non-power-of-two value from 3 upward.
    function automatic logic [7:0] tb_col(input int idx);
        int n = 0;
        for (int v = 3; v < 256; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (n == idx) return v[7:0];
                n++;
            end
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] encode(input logic [31:0] d);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 32; i++) if (d[i]) s ^= tb_col(i);
        return s;
    endfunction

    function automatic exp_t model(input logic [31:0] d, input logic [7:0] c, input logic [7:0] k);
        exp_t       r;
        logic [7:0] e;
        e = encode(d) ^ c ^ k ^ KEY_INV;
        r.data = d;
        r.corr = 1'b0;
        r.err  = 1'b0;
        if (e != 8'h00) begin
            r.err = 1'b1;
            for (int i = 0; i < 32; i++) begin
                if (e == tb_col(i)) begin
                    r.data[i] = ~d[i];
                    r.corr = 1'b1;
                    r.err  = 1'b0;
                end
            end
            if ((e & (e - 8'h01)) == 8'h00) begin
                r.corr = 1'b1;
                r.err  = 1'b0;
            end
        end
        return r;
    endfunction

    // Monitor on the falling edge: hold-stability, output compare, input push.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'(data_out), 64'(held.data));
                check("hold_flags", 64'({corr_flag, err_flag}), 64'({held.corr, held.err}));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("out_data", 64'(data_out), 64'(e.data));
                    check("out_corr", 64'(corr_flag), 64'(e.corr));
                    check("out_err", 64'(err_flag), 64'(e.err));
                end
                n_out++;
            end
            stall_prev = out_valid && !out_ready;
            held       = '{data: data_out, corr: corr_flag, err: err_flag};
            if (in_valid && in_ready) sb.push_back(model(data_in, check_in, tb_key));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic [7:0] c);
        int n = 0;
        in_valid = 1'b1;
        data_in  = d;
        check_in = c;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            n++;
            @(posedge clk);
        end
        #1 check("drain", 64'(sb.size()), 64'(0));
    endtask

    task automatic load_key(input logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            key_shift = 1'b1;
            key_bit   = k[i];
            @(posedge clk);
            #1;
        end
        key_shift  = 1'b0;
        key_commit = 1'b1;
        @(posedge clk);
        #1 key_commit = 1'b0;
        tb_key = k;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  c;
        rst_n = 1'b0; key_shift = 1'b0; key_bit = 1'b0; key_commit = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; data_in = '0; check_in = '0;

        // Reset state.
        #12;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outputs", 64'({data_out, corr_flag, err_flag}), 64'(0));
        check("rst_key_armed", 64'(key_armed), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Commit while LOCKED is ignored.
        key_commit = 1'b1;
        @(posedge clk); #1 key_commit = 1'b0;
        check("commit_locked", 64'(key_armed), 64'(0));

        // Reset key: zero word decodes as uncorrectable.
        send_word(32'h0, 8'h00);
        drain();

        // Load the correct key, then check the two-cycle latency.
        @(posedge clk); #1;
        load_key(8'hA5);
        check("key_armed", 64'(key_armed), 64'(1));
        in_valid = 1'b1; data_in = 32'h0; check_in = 8'h00;
        @(negedge clk) check("lat_accept", 64'(in_ready), 64'(1));
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk) check("lat_cycle1", 64'(out_valid), 64'(0));
        @(negedge clk) check("lat_cycle2", 64'(out_valid), 64'(1));
        drain();

        // Single data error on bit 0.
        @(posedge clk); #1;
        send_word(32'h1, 8'h00);

        // Mixed back-to-back traffic: clean, data flip, check flip, double flip.
        for (int i = 0; i < 24; i++) begin
            d = $urandom;
            c = encode(d);
            case (i % 4)
                1: d[$urandom_range(31, 0)] ^= 1'b1;
                2: c[$urandom_range(7, 0)] ^= 1'b1;
                3: d ^= 32'h0000_0003 << $urandom_range(30, 0);
                default: ;
            endcase
            send_word(d, c);
        end
        drain();

        // Four words with the consumer stalled for three cycles.
        @(posedge clk); #1 out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    d = 32'h1000_0000 + i;
                    send_word(d, encode(d) ^ ((i == 2) ? 8'h04 : 8'h00));
                end
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                check("stall_in_ready", 64'(in_ready), 64'(0));
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Shift and commit together: shift only, key_act unchanged.
        @(posedge clk); #1;
        key_shift = 1'b1; key_bit = 1'b0; key_commit = 1'b1;
        @(posedge clk); #1 key_shift = 1'b0; key_commit = 1'b0;
        check("shift_commit_armed", 64'(key_armed), 64'(0));
        send_word(32'h10, 8'h00);
        drain();
        // A lone commit now loads the shifted shadow (A5 >> 1 = 52).
        @(posedge clk); #1 key_commit = 1'b1;
        @(posedge clk); #1 key_commit = 1'b0;
        tb_key = 8'h52;
        check("commit_after_shift", 64'(key_armed), 64'(1));
        send_word(32'h0, 8'h00);
        drain();
        @(posedge clk); #1;
        load_key(8'hA5);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) send_word(32'h1, 8'h00);
        drain();
`ifdef SEC_LOCK_ERR_COUNT_EN
        check("err_cnt_sat", 64'(err_cnt), 64'(255));
`else
        check("err_cnt_off", 64'(err_cnt), 64'(0));
`endif

        // Reset mid-stream discards in-flight words and the key.
        begin
            int n_saved;
            @(posedge clk); #1;
            in_valid = 1'b1; data_in = 32'h55AA_0F0F; check_in = encode(32'h55AA_0F0F);
            repeat (2) @(posedge clk);
            #3 rst_n = 1'b0;
            in_valid = 1'b0;
            #1;
            check("midrst_out_valid", 64'(out_valid), 64'(0));
            check("midrst_in_ready", 64'(in_ready), 64'(1));
            check("midrst_key_armed", 64'(key_armed), 64'(0));
            check("midrst_err_cnt", 64'(err_cnt), 64'(0));
            sb.delete();
            n_saved = n_out;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (10) @(posedge clk);
            #1 check("midrst_no_output", 64'(n_out), 64'(n_saved));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
